// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings,
// requester IDs and the S1 pipeline payload.
package alu_share_pkg;

  localparam logic [1:0] OP_SHL_SHR  = 2'd0;
  localparam logic [1:0] OP_ADD2B    = 2'd1;
  localparam logic [1:0] OP_NEG      = 2'd2;
  localparam logic [1:0] OP_ABSDIFF3 = 2'd3;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       id;
  } s1_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between the two client engines, the result consumer
// and the shared-ALU arbiter.
interface alu_share_arbiter_if;

  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [1:0] req0_op;

  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [1:0] req1_op;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/problem_three.sv
// Four-function combinational 8-bit ALU; every result is truncated to 8 bits.
module problem_three
  import alu_share_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] s,
  output logic [7:0] out
);

  logic [9:0] a3;
  logic [9:0] b_ext;
  logic [7:0] abs_diff;

  // 3a needs 10 bits so the magnitude compare sees the true value.
  always_comb begin
    a3       = {2'b00, a} + {1'b0, a, 1'b0};
    b_ext    = {2'b00, b};
    abs_diff = 8'((a3 >= b_ext) ? (a3 - b_ext) : (b_ext - a3));
  end

  always_comb begin
    out = 8'd0;
    case (s)
      OP_SHL_SHR:  out = {a[5:0], 2'b00} + {2'b00, b[7:2]};
      OP_ADD2B:    out = a + {b[6:0], 1'b0};
      OP_NEG:      out = 8'd0 - b;
      OP_ABSDIFF3: out = abs_diff;
      default:     out = 8'd0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters through a
// two-stage pipeline (operands in S1, result in S2) with response back-pressure.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  s1_t              s1_q, s1_d;
  logic             v1_q, v1_d;
  logic [7:0]       res_q, res_d;
  logic             id2_q, id2_d;
  logic             v2_q, v2_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             advance;
  logic             acc0;
  logic             acc1;
  logic [7:0]       alu_out;

  problem_three u_alu (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .s   (s1_q.op),
    .out (alu_out)
  );

  // The whole pipeline moves only when S2 is empty or being drained.
  assign advance        = !v2_q || bus.rsp_ready;
  assign bus.req0_ready = advance && (last_grant_q == REQ_ID1 || !bus.req1_valid);
  assign bus.req1_ready = advance && (last_grant_q == REQ_ID0 || !bus.req0_valid);
  assign acc0           = bus.req0_valid && bus.req0_ready;
  assign acc1           = bus.req1_valid && bus.req1_ready;

  assign bus.rsp_valid = v2_q;
  assign bus.rsp_data  = res_q;
  assign bus.rsp_id    = id2_q;
  assign busy          = v1_q || v2_q;
  assign cnt0          = cnt0_q;
  assign cnt1          = cnt1_q;

  always_comb begin
    s1_d         = s1_q;
    v1_d         = v1_q;
    res_d        = res_q;
    id2_d        = id2_q;
    v2_d         = v2_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (advance) begin
      v2_d = v1_q;
      if (v1_q) begin
        res_d = alu_out;
        id2_d = s1_q.id;
      end
      v1_d = acc0 || acc1;
      if (acc0) begin
        s1_d = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op, id: REQ_ID0};
      end else if (acc1) begin
        s1_d = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op, id: REQ_ID1};
      end
    end

    // Both accepts are already qualified by advance through the ready terms.
    if (acc0) begin
      last_grant_d = REQ_ID0;
      if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (acc1) begin
      last_grant_d = REQ_ID1;
      if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      v1_q         <= 1'b0;
      res_q        <= 8'd0;
      id2_q        <= 1'b0;
      v2_q         <= 1'b0;
      last_grant_q <= REQ_ID1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      s1_q         <= s1_d;
      v1_q         <= v1_d;
      res_q        <= res_d;
      id2_q        <= id2_d;
      v2_q         <= v2_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes hand-computed
// results at acceptance, a negedge monitor pops them as responses drain.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       busy_w;
  logic [7:0] cnt0_w, cnt1_w;
  logic       busy_s;
  logic [1:0] cnt0_s, cnt1_s;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cycle  = 0;
  exp_t sb_q[$];
  int   acc_ids[$];
  int   acc_cyc[$];
  int   acc_rspv[$];

  alu_share_arbiter_if bus ();
  alu_share_arbiter_if bus_s ();

  alu_share_arbiter #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy_w),
    .cnt0 (cnt0_w),
    .cnt1 (cnt1_w)
  );

  alu_share_arbiter #(.CNT_W(2)) dut_sat (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_s),
    .busy (busy_s),
    .cnt0 (cnt0_s),
    .cnt1 (cnt1_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Response monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("rsp_data", int'(bus.rsp_data), int'(e.data));
        checkOutput("rsp_id", int'(bus.rsp_id), int'(e.id));
      end
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic applyStimulus(input logic id, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] res);
    int waits = 0;
    logic rdy;
    if (id == REQ_ID0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
    forever begin
      @(negedge clk);
      rdy = (id == REQ_ID0) ? bus.req0_ready : bus.req1_ready;
      if (rdy) break;
      waits++;
      if (waits > 50) break;
      @(posedge clk); #1;
    end
    if (!rdy) begin
      checkOutput("ready_timeout", 0, 1);
    end else begin
      sb_q.push_back('{id: id, data: res});
      acc_ids.push_back(int'(id));
      acc_cyc.push_back(cycle);
      acc_rspv.push_back(int'(bus.rsp_valid));
    end
    @(posedge clk); #1;
    if (id == REQ_ID0) bus.req0_valid = 1'b0;
    else               bus.req1_valid = 1'b0;
  endtask

  task automatic singleOp(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] res);
    applyStimulus(id, a, b, op, res);
    @(negedge clk);
    checkOutput("lat_not_yet", int'(bus.rsp_valid), 0);
    checkOutput("lat_busy", int'(busy_w), 1);
    @(negedge clk);
    checkOutput("lat_valid", int'(bus.rsp_valid), 1);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle();
    int w = 0;
    while ((busy_w || sb_q.size() != 0) && w < 60) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_idle", int'(busy_w), 0);
    @(posedge clk); #1;
  endtask

  task automatic clearLog();
    acc_ids.delete();
    acc_cyc.delete();
    acc_rspv.delete();
  endtask

  vec_t cont0[3];
  vec_t cont1[3];
  vec_t bp[3];
  vec_t da[4];
  int   cont_order[6];

  initial begin
    cont0 = '{'{8'd1, 8'd1, OP_ADD2B, 8'd3},
              '{8'd2, 8'd0, OP_SHL_SHR, 8'd8},
              '{8'd0, 8'd5, OP_NEG, 8'd251}};
    cont1 = '{'{8'd4, 8'd4, OP_ADD2B, 8'd12},
              '{8'd3, 8'd8, OP_ABSDIFF3, 8'd1},
              '{8'd0, 8'd0, OP_NEG, 8'd0}};
    bp    = '{'{8'd1, 8'd2, OP_ADD2B, 8'd5},
              '{8'd3, 8'd4, OP_SHL_SHR, 8'd13},
              '{8'd0, 8'd9, OP_NEG, 8'd247}};
    da    = '{'{8'd10, 8'd20, OP_ADD2B, 8'd50},
              '{8'd6, 8'd6, OP_ABSDIFF3, 8'd12},
              '{8'd255, 8'd255, OP_SHL_SHR, 8'd59},
              '{8'd0, 8'd128, OP_NEG, 8'd128}};
    cont_order = '{0, 1, 0, 1, 0, 1};

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req0_op = 2'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0; bus.req1_op = 2'd0;
    bus.rsp_ready  = 1'b1;
    bus_s.req0_valid = 1'b0; bus_s.req0_a = 8'd7; bus_s.req0_b = 8'd3; bus_s.req0_op = 2'd1;
    bus_s.req1_valid = 1'b0; bus_s.req1_a = 8'd0; bus_s.req1_b = 8'd0; bus_s.req1_op = 2'd0;
    bus_s.rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("rst_rsp_data", int'(bus.rsp_data), 0);
    checkOutput("rst_rsp_id", int'(bus.rsp_id), 0);
    checkOutput("rst_busy", int'(busy_w), 0);
    checkOutput("rst_cnt0", int'(cnt0_w), 0);
    checkOutput("rst_cnt1", int'(cnt1_w), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] contention");
    clearLog();
    fork
      begin
        for (int i = 0; i < 3; i++)
          applyStimulus(REQ_ID0, cont0[i].a, cont0[i].b, cont0[i].op, cont0[i].res);
      end
      begin
        for (int j = 0; j < 3; j++)
          applyStimulus(REQ_ID1, cont1[j].a, cont1[j].b, cont1[j].op, cont1[j].res);
      end
    join
    waitIdle();
    checkOutput("cont_accepts", acc_ids.size(), 6);
    for (int k = 0; k < 6 && k < acc_ids.size(); k++)
      checkOutput($sformatf("cont_grant%0d", k), acc_ids[k], cont_order[k]);
    checkOutput("cont_cycles", acc_cyc[acc_cyc.size()-1] - acc_cyc[0], 5);
    checkOutput("cont_cnt0", int'(cnt0_w), 3);
    checkOutput("cont_cnt1", int'(cnt1_w), 3);

    $display("[TB] single ops");
    singleOp(REQ_ID0, 8'd5, 8'd12, OP_SHL_SHR, 8'd23);
    singleOp(REQ_ID0, 8'd100, 8'd100, OP_ADD2B, 8'd44);
    singleOp(REQ_ID1, 8'd0, 8'd1, OP_NEG, 8'd255);
    singleOp(REQ_ID0, 8'd10, 8'd40, OP_ABSDIFF3, 8'd10);
    singleOp(REQ_ID1, 8'd200, 8'd0, OP_ABSDIFF3, 8'd88);
    waitIdle();

    $display("[TB] back-pressure");
    bus.rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          applyStimulus(REQ_ID0, bp[i].a, bp[i].b, bp[i].op, bp[i].res);
      end
      begin
        int w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.rsp_valid && w < 50);
        checkOutput("bp_valid", int'(bus.rsp_valid), 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("bp_hold_valid", int'(bus.rsp_valid), 1);
          checkOutput("bp_hold_data", int'(bus.rsp_data), 5);
          checkOutput("bp_hold_id", int'(bus.rsp_id), 0);
          checkOutput("bp_req0_ready", int'(bus.req0_ready), 0);
          checkOutput("bp_req1_ready", int'(bus.req1_ready), 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
      end
    join
    waitIdle();

    $display("[TB] drain and accept");
    clearLog();
    for (int i = 0; i < 4; i++)
      applyStimulus(REQ_ID1, da[i].a, da[i].b, da[i].op, da[i].res);
    waitIdle();
    checkOutput("da_accepts", acc_cyc.size(), 4);
    for (int k = 1; k < 4 && k < acc_cyc.size(); k++)
      checkOutput($sformatf("da_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 1);
    if (acc_rspv.size() == 4) begin
      checkOutput("da_rspv_at_accept2", acc_rspv[2], 1);
      checkOutput("da_rspv_at_accept3", acc_rspv[3], 1);
    end

    $display("[TB] reset mid-operation");
    bus.rsp_ready = 1'b0;
    applyStimulus(REQ_ID0, 8'd1, 8'd1, OP_SHL_SHR, 8'd4);
    applyStimulus(REQ_ID0, 8'd2, 8'd2, OP_SHL_SHR, 8'd8);
    checkOutput("pre_rst_busy", int'(busy_w), 1);
    checkOutput("pre_rst_valid", int'(bus.rsp_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(bus.rsp_valid), 0);
    checkOutput("mid_rst_busy", int'(busy_w), 0);
    checkOutput("mid_rst_cnt0", int'(cnt0_w), 0);
    checkOutput("mid_rst_cnt1", int'(cnt1_w), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    clearLog();
    fork
      applyStimulus(REQ_ID0, 8'd9, 8'd3, OP_ADD2B, 8'd15);
      applyStimulus(REQ_ID1, 8'd50, 8'd0, OP_ABSDIFF3, 8'd150);
    join
    waitIdle();
    checkOutput("post_rst_accepts", acc_ids.size(), 2);
    if (acc_ids.size() == 2) begin
      checkOutput("post_rst_first", acc_ids[0], 0);
      checkOutput("post_rst_second", acc_ids[1], 1);
    end

    $display("[TB] counter saturation");
    @(posedge clk); #1;
    bus_s.req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_cnt0_after2", int'(cnt0_s), 2);
    repeat (3) @(posedge clk);
    #1;
    bus_s.req0_valid = 1'b0;
    checkOutput("sat_cnt0", int'(cnt0_s), 3);
    checkOutput("sat_cnt1", int'(cnt1_s), 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 4-function 8-bit ALU (`problem_three`) between two requesters. Arbitration is round-robin.
- Each requester sends a, b and a 2-bit op over a valid/ready handshake.
- The block registers operands, runs the ALU, registers the result and returns it with the winning requester's ID over a valid/ready response channel.
- It sits between two client engines and the single shared ALU, giving full throughput (1 op/cycle) with back-pressure.

Parameters:
- CNT_W, 8, width of the per-requester accepted-op counters (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle when valid&ready.
- req0_a  input  8  requester 0 operand a.
- req0_b  input  8  requester 0 operand b.
- req0_op  input  2  requester 0 function select.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  8  ALU result.
- rsp_id  output  1  requester that issued the op.
- busy  output  1  any pipeline stage valid.
- cnt0  output  CNT_W  ops accepted from requester 0 (saturating).
- cnt1  output  CNT_W  ops accepted from requester 1 (saturating).

Behaviour:
- Reset (async, active-high): all stage valid bits 0, last_grant=1 (requester 0 wins first), cnt0=cnt1=0. rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. Reset mid-operation discards all in-flight ops; no response is produced for them.
- ALU function, all results truncated to 8 bits:
  - op0 = (a<<2)+(b>>2)
  - op1 = a+2b
  - op2 = -b
  - op3 = |3a-b|, where 3a is computed at ≥10-bit width before comparing and subtracting.
- Pipeline:
  - S1 register holds {a,b,op,id,v1}.
  - S2 register holds {result,id,v2}. The ALU is combinational between S1 and S2.
  - advance = !v2 | rsp_ready. When advance=0, S1 and S2 both hold.
- Ready rules:
  - req0_ready = advance & (last_grant==1 | !req1_valid).
  - req1_ready = advance & (last_grant==0 | !req0_valid).
  - Neither ready depends on its own valid. When both requesters are valid, exactly one is ready.
- Handshake at edge when advance=1:
  - S2 <= {ALU(S1), S1.id, v1}.
  - S1 <= accepted request (v1=1) or v1=0 if none accepted.
- last_grant updates only on an accepted request, to the accepted ID.
- Latency: request handshake at edge N → rsp_valid=1 after edge N+1 (2-cycle latency). Back-to-back throughput is 1 op/cycle while rsp_ready=1.
- Response rule: rsp_valid=v2; rsp_data and rsp_id are stable while rsp_valid & !rsp_ready.
- Ordering: responses return in acceptance order; no reordering.
- Stall: rsp_ready=0 with v2=1 → both req_ready=0, no state changes except counters hold.
- Simultaneous drain and accept: with v2=1 and rsp_ready=1, a new request is accepted the same cycle.
- Counters: cntX increments on each reqX handshake and saturates at 2^CNT_W-1.
- busy = v1 | v2.
- Input operands are sampled only at handshake. A requester must hold a/b/op stable while valid & !ready.

Decomposition:
- Shared package alu_share_pkg: op encoding constants OP_SHL_SHR=2'd0, OP_ADD2B=2'd1, OP_NEG=2'd2, OP_ABSDIFF3=2'd3; requester ID constants.
- One sub-module: instantiate the existing `problem_three` ALU (a, b, s, out) unmodified between S1 and S2.
- Arbiter and pipeline registers stay in the top module.

Test Plan:
- Single op, per function:
  - req0 {a=5, b=12, op0} → rsp_data=23, rsp_id=0, two cycles after handshake.
  - op1 a=100, b=100 → 44.
  - op2 b=1 → 255.
  - op3 a=10, b=40 → 10.
  - op3 a=200, b=0 → 88.
- Contention: both valid continuously for 6 cycles, rsp_ready=1 → grants alternate 0,1,0,1,0,1; rsp_id follows the same order; cnt0=cnt1=3.
- Back-pressure: 3 ops issued, rsp_ready=0 for 4 cycles → rsp_data/rsp_id stable; req_ready=0 while S2 full; after release all 3 results appear in order with no loss or duplication.
- Simultaneous drain and accept: v2=1, rsp_ready=1 and req1_valid in the same cycle → request accepted that cycle, throughput stays 1/cycle.
- Reset mid-operation: assert rst with v1=v2=1 → rsp_valid=0 and busy=0 immediately (async); counters=0; first post-reset grant goes to requester 0.
- Counter saturation: CNT_W=2, 5 ops from req0 → cnt0=3, cnt1=0.
